// File: rtl/tt_um_fsm_seq_pkg.sv
// Shared constants for the start/count/done sequencer: state encoding,
// ui_in field positions and uio_out bit positions.
package tt_um_fsm_seq_pkg;

    // State codes, also driven out on uio_out[1:0]
    localparam logic [1:0] ST_CODE_IDLE  = 2'd0;
    localparam logic [1:0] ST_CODE_LOAD  = 2'd1;
    localparam logic [1:0] ST_CODE_COUNT = 2'd2;
    localparam logic [1:0] ST_CODE_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_CODE_IDLE,
        ST_LOAD  = ST_CODE_LOAD,
        ST_COUNT = ST_CODE_COUNT,
        ST_DONE  = ST_CODE_DONE
    } state_t;

    // ui_in field indices
    localparam int UI_START   = 0;
    localparam int UI_ABORT   = 1;
    localparam int UI_MODE    = 2;
    localparam int UI_TGT_LSB = 4;
    localparam int UI_TGT_MSB = 7;

    // uio_out bit indices
    localparam int UIO_STATE_LSB = 0;
    localparam int UIO_STATE_MSB = 1;
    localparam int UIO_DONE      = 2;
    localparam int UIO_BUSY      = 3;
    localparam int UIO_TICK      = 4;

endpackage

// File: rtl/tt_um_fsm_seq_prescaler.sv
// Tick generator: counts 0..PRESCALE-1 while run is high and flags the
// last cycle of each period. Dropping run returns the count to zero, so
// every run starts with a full period.
module fsm_prescaler #(
    parameter logic [23:0] PRESCALE = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int PW = (PRESCALE > 24'd1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 24'd1);

    logic [PW-1:0] r_presc;
    logic          w_last;

    // With PRESCALE=1 the counter sits at zero, which is also LAST, so
    // tick follows run every cycle.
    assign w_last = (r_presc == LAST);
    assign tick   = run & w_last;

    // Period counter: cleared whenever idle, wraps after the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!run || w_last) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

endmodule

// File: rtl/tt_um_fsm_seq.sv
// Start/abort sequencer: on a start edge it latches a target and mode,
// counts prescaled ticks up to the target, pulses done, then either
// returns to IDLE (one-shot) or reloads (auto-reload).
module tt_um_fsm_seq
    import tt_um_fsm_seq_pkg::*;
#(
    parameter logic [23:0] PRESCALE = 24'd10_000_000,
    parameter int          CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [CNT_W-1:0]   w_count_inc;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   w_target_in;
    logic               r_mode;
    logic               r_done;
    logic               r_busy;
    logic               w_load;
    logic               w_tick;
    logic               w_run;
    logic               w_stop;
    logic [7:0]         w_uio_out;

    // Synchronisers, edge detector and post-reset arming
    logic               r_start_s1;
    logic               r_start_s2;
    logic               r_start_s3;
    logic               r_abort_s1;
    logic               r_abort_s2;
    logic [1:0]         r_fill;
    logic               r_armed;
    logic               w_start_edge;
    logic               w_unused;

    assign w_unused = ^{uio_in, ui_in[3]};

    // Synchronise start/abort; arm the edge detector only after the
    // synchroniser holds real samples and has shown start low, so a start
    // line already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_s3 <= 1'b0;
            r_abort_s1 <= 1'b0;
            r_abort_s2 <= 1'b0;
            r_fill     <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_start_s1 <= ui_in[UI_START];
            r_start_s2 <= r_start_s1;
            r_start_s3 <= r_start_s2;
            r_abort_s1 <= ui_in[UI_ABORT];
            r_abort_s2 <= r_abort_s1;
            r_fill     <= {r_fill[0], 1'b1};
            r_armed    <= r_armed | (r_fill[1] & ~r_start_s2);
        end
    end

    assign w_start_edge = r_start_s2 & ~r_start_s3 & r_armed;

    // Prescaler only advances while counting
    assign w_run = (r_state == ST_COUNT);

    fsm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .tick  (w_tick)
    );

    assign w_target_in = CNT_W'(ui_in[UI_TGT_MSB:UI_TGT_LSB]);
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_stop      = r_abort_s2 | ~ena;

    // Next-state and count logic; abort/disable is checked first so it
    // beats completion in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ena && w_start_edge && !r_abort_s2) begin
                    w_state_next = ST_LOAD;
                    w_count_next = '0;
                end
            end
            ST_LOAD: begin
                w_count_next = '0;
                if (w_stop) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_state_next = (w_target_in == '0) ? ST_DONE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_stop) begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end else if (w_tick) begin
                    w_count_next = w_count_inc;
                    if (w_count_inc == r_target) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_stop) begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end else if (r_mode) begin
                    w_state_next = ST_LOAD;
                    w_count_next = '0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    // State, counter, latched run parameters and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_done  <= (w_state_next == ST_DONE);
            r_busy  <= (w_state_next == ST_LOAD) || (w_state_next == ST_COUNT);
            if (w_load) begin
                r_target <= w_target_in;
                r_mode   <= ui_in[UI_MODE];
            end
        end
    end

    // Status byte assembled from the current-state registers
    always_comb begin
        w_uio_out = 8'h00;
        w_uio_out[UIO_STATE_MSB:UIO_STATE_LSB] = r_state;
        w_uio_out[UIO_DONE] = r_done;
        w_uio_out[UIO_BUSY] = r_busy;
        w_uio_out[UIO_TICK] = w_tick;
    end

    assign uo_out  = 8'(r_count);
    assign uio_out = w_uio_out;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_fsm_seq.sv
// Directed bench for the sequencer: a vector table for the basic one-shot
// run plus hand-written sequences for the multi-cycle corner cases.
// dut runs PRESCALE=2/CNT_W=4, dut2 runs PRESCALE=1/CNT_W=8.
module tb_tt_um_fsm_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena2;
    logic [7:0] ui_in2;
    logic [7:0] uo_out2;
    logic [7:0] uio_out2;
    logic [7:0] uio_oe2;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] ui;
        logic       en;
        logic [7:0] uo;
        logic [7:0] uio;
    } vec_t;

    vec_t tbl[12];

    tt_um_fsm_seq #(.PRESCALE(24'd2), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (8'h00),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    tt_um_fsm_seq #(.PRESCALE(24'd1), .CNT_W(8)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena2),
        .ui_in   (ui_in2),
        .uio_in  (8'h00),
        .uo_out  (uo_out2),
        .uio_out (uio_out2),
        .uio_oe  (uio_oe2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] exp_uo, input logic [7:0] exp_uio);
        n_vec++;
        if (uo_out !== exp_uo || uio_out !== exp_uio) begin
            n_bad++;
            $display("FAIL %s: got uo_out=%h uio_out=%h, expected uo_out=%h uio_out=%h",
                     name, uo_out, uio_out, exp_uo, exp_uio);
        end else begin
            $display("ok   %s: uo_out=%h uio_out=%h", name, uo_out, uio_out);
        end
    endtask

    task automatic chk2(input string name, input logic [7:0] exp_uo, input logic [7:0] exp_uio);
        n_vec++;
        if (uo_out2 !== exp_uo || uio_out2 !== exp_uio) begin
            n_bad++;
            $display("FAIL %s: got uo_out=%h uio_out=%h, expected uo_out=%h uio_out=%h",
                     name, uo_out2, uio_out2, exp_uo, exp_uio);
        end else begin
            $display("ok   %s: uo_out=%h uio_out=%h", name, uo_out2, uio_out2);
        end
    endtask

    // Step dut until uio_out equals want, bounded by max cycles
    task automatic wait_uio(input string name, input logic [7:0] want, input int max);
        for (int i = 0; i < max && uio_out !== want; i++) cyc(1);
        if (uio_out !== want) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout, uio_out=%h, expected %h within %0d cycles",
                     name, uio_out, want, max);
        end
    endtask

    task automatic wait_uio2(input string name, input logic [7:0] want, input int max);
        for (int i = 0; i < max && uio_out2 !== want; i++) cyc(1);
        if (uio_out2 !== want) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout, uio_out=%h, expected %h within %0d cycles",
                     name, uio_out2, want, max);
        end
    endtask

    initial begin
        // One-shot run, target=3: start rises, 2-cycle sync, LOAD, 6 COUNT
        // cycles (tick every 2nd), DONE, then IDLE holding 3.
        tbl[0]  = '{8'h31, 1'b1, 8'h00, 8'h00};
        tbl[1]  = '{8'h31, 1'b1, 8'h00, 8'h00};
        tbl[2]  = '{8'h31, 1'b1, 8'h00, 8'h09};
        tbl[3]  = '{8'h31, 1'b1, 8'h00, 8'h0A};
        tbl[4]  = '{8'h31, 1'b1, 8'h00, 8'h1A};
        tbl[5]  = '{8'h31, 1'b1, 8'h01, 8'h0A};
        tbl[6]  = '{8'h31, 1'b1, 8'h01, 8'h1A};
        tbl[7]  = '{8'h31, 1'b1, 8'h02, 8'h0A};
        tbl[8]  = '{8'h31, 1'b1, 8'h02, 8'h1A};
        tbl[9]  = '{8'h31, 1'b1, 8'h03, 8'h07};
        tbl[10] = '{8'h31, 1'b1, 8'h03, 8'h00};
        tbl[11] = '{8'h31, 1'b1, 8'h03, 8'h00};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        ena2   = 1'b1;
        ui_in2 = 8'h00;
        cyc(2);
        chk("reset_state", 8'h00, 8'h00);
        n_vec++;
        if (uio_oe !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_oe: got uio_oe=%h, expected ff", uio_oe);
        end
        rst_n = 1'b1;
        cyc(5);

        for (int i = 0; i < 12; i++) begin
            ui_in = tbl[i].ui;
            ena   = tbl[i].en;
            cyc(1);
            chk($sformatf("oneshot_v%0d", i), tbl[i].uo, tbl[i].uio);
        end

        // Target 0: LOAD -> DONE -> IDLE, count 0, no tick
        ui_in = 8'h00;
        cyc(3);
        ui_in = 8'h01;
        cyc(2);
        chk("t0_idle_holds_3", 8'h03, 8'h00);
        cyc(1); chk("t0_load", 8'h00, 8'h09);
        cyc(1); chk("t0_done", 8'h00, 8'h07);
        cyc(1); chk("t0_idle", 8'h00, 8'h00);
        cyc(1); chk("t0_idle2", 8'h00, 8'h00);

        // Auto-reload target 2, target changed to 4 during the second run
        ui_in = 8'h24;
        cyc(3);
        ui_in = 8'h25;
        wait_uio("ar_wait1", 8'h07, 30);
        chk("ar_run1_done", 8'h02, 8'h07);
        cyc(1); chk("ar_run2_load", 8'h00, 8'h09);
        cyc(1); chk("ar_run2_count", 8'h00, 8'h0A);
        ui_in = 8'h45;
        wait_uio("ar_wait2", 8'h07, 30);
        chk("ar_run2_done", 8'h02, 8'h07);
        cyc(1); chk("ar_run3_load", 8'h00, 8'h09);
        wait_uio("ar_wait3", 8'h07, 30);
        chk("ar_run3_done", 8'h04, 8'h07);
        ui_in = 8'h47;
        cyc(3);
        chk("ar_abort_idle", 8'h00, 8'h00);

        // Abort held in IDLE blocks a start edge
        ui_in = 8'h02;
        cyc(4);
        ui_in = 8'h03;
        cyc(4);
        chk("abort_blocks_start", 8'h00, 8'h00);
        ui_in = 8'h01;
        cyc(3);
        chk("no_queued_start", 8'h00, 8'h00);

        // Abort while count=1
        ui_in = 8'h00;
        cyc(3);
        ui_in = 8'h31;
        wait_uio("ab1_wait_tick", 8'h1A, 20);
        ui_in = 8'h33;
        cyc(1); chk("ab1_count1", 8'h01, 8'h0A);
        cyc(1); chk("ab1_count1_tick", 8'h01, 8'h1A);
        cyc(1); chk("ab1_idle", 8'h00, 8'h00);
        cyc(1); chk("ab1_no_done", 8'h00, 8'h00);

        // Abort arriving in the completion cycle (target 1)
        ui_in = 8'h00;
        cyc(3);
        ui_in = 8'h11;
        wait_uio("ab2_wait_load", 8'h09, 20);
        ui_in = 8'h13;
        cyc(1); chk("ab2_count", 8'h00, 8'h0A);
        cyc(1); chk("ab2_complete_cycle", 8'h00, 8'h1A);
        cyc(1); chk("ab2_idle_no_done", 8'h00, 8'h00);
        cyc(1); chk("ab2_still_idle", 8'h00, 8'h00);

        // Reset mid-COUNT with start held high
        ui_in = 8'h00;
        cyc(3);
        ui_in = 8'h31;
        wait_uio("rst_wait_count", 8'h0A, 20);
        cyc(1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8);
        chk("rst_no_start_held", 8'h00, 8'h00);
        ui_in = 8'h30;
        cyc(3);
        ui_in = 8'h31;
        wait_uio("rst_wait_load", 8'h09, 6);
        chk("rst_fresh_start", 8'h00, 8'h09);
        cyc(1); chk("ena_run_count", 8'h00, 8'h0A);
        ena = 1'b0;
        cyc(1); chk("ena_low_idle", 8'h00, 8'h00);
        ena = 1'b1;
        cyc(2); chk("ena_back_idle", 8'h00, 8'h00);

        // PRESCALE=1, CNT_W=8, target 15: count steps every cycle
        ui_in2 = 8'hF1;
        wait_uio2("p1_wait_load", 8'h09, 10);
        chk2("p1_load", 8'h00, 8'h09);
        cyc(1); chk2("p1_count0", 8'h00, 8'h1A);
        for (int k = 1; k < 15; k++) begin
            cyc(1);
            chk2($sformatf("p1_count%0d", k), 8'(k), 8'h1A);
        end
        cyc(1); chk2("p1_done", 8'h0F, 8'h07);
        cyc(1); chk2("p1_idle", 8'h0F, 8'h00);
        cyc(1); chk2("p1_done_once", 8'h0F, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
